// File: rtl/param_pkg.sv
// param_pkg: shared address map, control bit indices and loader state encoding.
package param_pkg;
    localparam int ADDR_CTRL    = 0;
    localparam int ADDR_MAXX_LO = 1;
    localparam int ADDR_MAXX_HI = 2;
    localparam int ADDR_MAXY_LO = 3;
    localparam int ADDR_MAXY_HI = 4;
    localparam int ADDR_KSIZE   = 5;
    localparam int ADDR_SIGMA   = 6;
    localparam int ADDR_RSVD    = 7;
    localparam int START_BIT    = 0;
    localparam int DONE_BIT     = 1;
    typedef enum logic [2:0] {IDLE, LOAD, ARM, POLL_WAIT, POLL_RD, POLL_CHK, CLEAR} state_t;
endpackage

// File: rtl/poll_timer.sv
// poll_timer: saturating up-counter; tc flags the enabled cycle whose increment reaches MAX.
module poll_timer #(
    parameter int MAX = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic tc
);
    localparam int W = $clog2(MAX + 1);
    logic [W-1:0] cnt;
    always_ff @(posedge clk)
        if (rst || load) cnt <= '0;
        else if (en && cnt != W'(MAX)) cnt <= cnt + 1'b1;
    assign tc = en && cnt == W'(MAX - 1);
endmodule

// File: rtl/param_loader.sv
// param_loader: streams host param bytes into the param SRAM, arms CTRL.START,
// polls CTRL.DONE with a timeout, then clears CTRL.
module param_loader
    import param_pkg::*;
#(
    parameter int NUM_PARAMS     = 8,
    parameter int BIT_DEPTH      = 8,
    parameter int POLL_INTERVAL  = 16,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [BIT_DEPTH-1:0]          s_data,
    output logic [$clog2(NUM_PARAMS)-1:0] addr_write_params,
    output logic                          wen_params,
    output logic [BIT_DEPTH-1:0]          wdat_params,
    output logic [$clog2(NUM_PARAMS)-1:0] addr_params,
    output logic                          ren_params,
    input  logic [BIT_DEPTH-1:0]          rdat_params,
    output logic                          busy,
    output logic                          done,
    output logic                          timeout
);
    localparam int AW = $clog2(NUM_PARAMS);
    state_t       state;
    logic [AW-1:0] idx;
    logic         cause_done;
    logic         beat, poll_tc, tmo_tc, rd_done, unused_rdat;

    poll_timer #(.MAX(POLL_INTERVAL)) u_poll (
        .clk(clk), .rst(rst), .load(state != POLL_WAIT), .en(state == POLL_WAIT), .tc(poll_tc)
    );
    poll_timer #(.MAX(TIMEOUT_CYCLES)) u_tmo (
        .clk(clk), .rst(rst), .load(state == ARM),
        .en(state == POLL_WAIT || state == POLL_RD || state == POLL_CHK), .tc(tmo_tc)
    );

    assign rd_done     = rdat_params[DONE_BIT];
    assign unused_rdat = ^rdat_params;

    always_ff @(posedge clk)
        if (rst) begin
            state      <= IDLE;
            idx        <= AW'(1);
            cause_done <= 1'b0;
        end else begin
            case (state)
                IDLE:      if (start) begin
                               state <= LOAD;
                               idx   <= AW'(1);
                           end
                LOAD:      if (s_valid) begin
                               idx <= idx + 1'b1;
                               if (idx == AW'(NUM_PARAMS - 1)) state <= ARM;
                           end
                ARM:       state <= POLL_WAIT;
                POLL_WAIT: if (tmo_tc) begin
                               state      <= CLEAR;
                               cause_done <= 1'b0;
                           end else if (poll_tc) state <= POLL_RD;
                POLL_RD:   if (tmo_tc) begin
                               state      <= CLEAR;
                               cause_done <= 1'b0;
                           end else state <= POLL_CHK;
                // DONE seen on the same cycle the timeout expires still counts as done
                POLL_CHK:  if (rd_done || tmo_tc) begin
                               state      <= CLEAR;
                               cause_done <= rd_done;
                           end else state <= POLL_WAIT;
                default:   state <= IDLE;
            endcase
        end

    // Gating with rst keeps a reset cycle from leaking a write into the SRAM
    assign beat              = !rst && state == LOAD && s_valid;
    assign s_ready           = !rst && state == LOAD;
    assign busy              = !rst && state != IDLE;
    assign wen_params        = beat || (!rst && (state == ARM || state == CLEAR));
    assign addr_write_params = beat ? idx : AW'(ADDR_CTRL);
    assign wdat_params       = beat ? s_data : (!rst && state == ARM) ? BIT_DEPTH'(1 << START_BIT) : '0;
    assign ren_params        = !rst && state == POLL_RD;
    assign addr_params       = AW'(ADDR_CTRL);
    assign done              = !rst && state == CLEAR && cause_done;
    assign timeout           = !rst && state == CLEAR && !cause_done;
endmodule

// File: tb/tb_param_loader.sv
// tb_param_loader: directed load/poll/timeout/reset sequence against a behavioural param SRAM.
module tb_param_loader;
    logic       clk = 0, rst = 1, start = 0, s_valid = 0;
    logic [7:0] s_data = 0;
    logic       s_ready, wen, ren, busy, done, timeout;
    logic [2:0] addr_w, addr_r;
    logic [7:0] wdat, rdat;
    logic [7:0] mem [8];
    logic       init_mem = 0, force_done = 0;
    logic [7:0] img [7] = '{8'h90, 8'h01, 8'h90, 8'h01, 8'h07, 8'h02, 8'h00};
    int wcount = 0, dcount = 0, tcount = 0, conflicts = 0;
    int checks = 0, errors = 0, lat = 0, w0 = 0;

    always #5 clk = ~clk;

    param_loader #(.NUM_PARAMS(8), .BIT_DEPTH(8), .POLL_INTERVAL(16), .TIMEOUT_CYCLES(100)) dut (
        .clk(clk), .rst(rst), .start(start), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .addr_write_params(addr_w), .wen_params(wen), .wdat_params(wdat),
        .addr_params(addr_r), .ren_params(ren), .rdat_params(rdat),
        .busy(busy), .done(done), .timeout(timeout)
    );

    // SRAM model plus event counters; a DUT write overrides a same-cycle host write
    always @(posedge clk) begin
        if (init_mem) for (int i = 0; i < 8; i++) mem[i] <= 8'hEE;
        if (force_done) mem[0] <= 8'h03;
        if (wen) begin
            mem[addr_w] <= wdat;
            wcount <= wcount + 1;
        end
        if (ren) rdat <= mem[addr_r];
        if (wen && ren) conflicts <= conflicts + 1;
        if (done) dcount <= dcount + 1;
        if (timeout) tcount <= tcount + 1;
    end

    function automatic logic [63:0] image();
        for (int i = 0; i < 8; i++) image[i*8 +: 8] = mem[i];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1;
        @(negedge clk);
        start = 0;
    endtask

    task automatic load_beats(input bit gaps);
        for (int i = 0; i < 7; i++) begin
            if (gaps) begin
                s_valid = 0;
                s_data  = 8'hAA;
                #1 chk("gap_no_write", wen, 0);
                @(negedge clk);
            end
            s_valid = 1;
            s_data  = img[i];
            @(negedge clk);
        end
        s_valid = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        init_mem = 1;
        @(negedge clk);
        @(negedge clk);
        init_mem = 0;
        chk("reset_outputs", {s_ready, wen, ren, busy, done, timeout, addr_w, wdat, addr_r}, 0);
        rst = 0;
        @(negedge clk);
        // Reset during the third beat
        pulse_start();
        chk("load_ready_busy", {s_ready, busy}, 2'b11);
        s_valid = 1;
        s_data  = 8'h90;
        #1 chk("first_beat", {wen, addr_w, wdat}, {1'b1, 3'd1, 8'h90});
        @(negedge clk);
        s_data = 8'h01;
        @(negedge clk);
        s_data = 8'h90;
        rst    = 1;
        #1 chk("rst_blocks_write", wen, 0);
        @(negedge clk);
        rst     = 0;
        s_valid = 0;
        #1 chk("post_rst_outputs", {s_ready, wen, ren, busy, done, timeout, addr_w, wdat, addr_r}, 0);
        chk("rst_sram_image", image(), 64'hEEEE_EEEE_EE01_90EE);
        chk("rst_write_count", wcount, 2);
        // Full load with continuous valid, then completion
        w0 = wcount;
        pulse_start();
        load_beats(0);
        #1 chk("arm_write", {wen, addr_w, wdat, s_ready}, {1'b1, 3'd0, 8'h01, 1'b0});
        lat = 0;
        @(negedge clk);
        lat = 1;
        chk("load_image", image(), 64'h0002_0701_9001_9001);
        force_done = 1;
        @(negedge clk);
        lat = 2;
        force_done = 0;
        while (!done && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        chk("done_latency", lat, 19);
        chk("clear_write", {wen, addr_w, wdat, timeout}, {1'b1, 3'd0, 8'h00, 1'b0});
        @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("ctrl_cleared", mem[0], 8'h00);
        chk("done_once", dcount, 1);
        chk("load_writes", wcount - w0, 9);
        // Gapped load, then no DONE so the run times out
        init_mem = 1;
        @(negedge clk);
        init_mem = 0;
        w0 = wcount;
        pulse_start();
        load_beats(1);
        chk("gap_arm_write", {wen, addr_w, wdat}, {1'b1, 3'd0, 8'h01});
        lat = 0;
        @(negedge clk);
        lat = 1;
        chk("gap_image", image(), 64'h0002_0701_9001_9001);
        while (!timeout && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        chk("timeout_window", (lat >= 99 && lat <= 101), 1);
        chk("timeout_no_done", done, 0);
        @(negedge clk);
        chk("timeout_ctrl_cleared", mem[0], 8'h00);
        chk("timeout_count", {tcount[15:0], dcount[15:0]}, {16'd1, 16'd1});
        chk("timeout_writes", wcount - w0, 9);
        chk("timeout_idle", busy, 0);
        // Start pulsed while polling must be ignored
        w0 = wcount;
        pulse_start();
        load_beats(0);
        @(negedge clk);
        start      = 1;
        force_done = 1;
        @(negedge clk);
        start      = 0;
        force_done = 0;
        lat = 0;
        while (!done && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        chk("restart_done_seen", done, 1);
        repeat (5) @(negedge clk);
        chk("restart_single_done", dcount, 2);
        chk("restart_writes", wcount - w0, 9);
        chk("restart_idle", busy, 0);
        chk("no_rw_conflict", conflicts, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/param_loader.md
PARAM_LOADER -- requirements
Module: param_loader

Interface
REQ-001 SHALL have parameter NUM_PARAMS, default 8, giving the param SRAM depth in bytes.
REQ-002 SHALL have parameter BIT_DEPTH, default 8, giving the param byte width.
REQ-003 SHALL have parameter POLL_INTERVAL, default 16, giving the idle cycles between status reads.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 65535, giving the max cycles from ARM to DONE.
REQ-005 SHALL have port clk, input, 1 bit: single clock, all logic on posedge.
REQ-006 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port start, input, 1 bit: begin a load/run cycle; sampled only in IDLE.
REQ-008 SHALL have port s_valid, input, 1 bit: host param byte valid.
REQ-009 SHALL have port s_ready, output, 1 bit: loader accepts a byte.
REQ-010 SHALL have port s_data, input, BIT_DEPTH bits: param byte.
REQ-011 SHALL have ports addr_write_params (output, $clog2(NUM_PARAMS) bits), wen_params (output, 1 bit) and wdat_params (output, BIT_DEPTH bits): host-side SRAM write port.
REQ-012 SHALL have ports addr_params (output, $clog2(NUM_PARAMS) bits), ren_params (output, 1 bit) and rdat_params (input, BIT_DEPTH bits): host-side SRAM read port; synchronous, 1-cycle latency.
REQ-013 SHALL have outputs busy, done and timeout, 1 bit each: busy = not IDLE; done and timeout are 1-cycle pulses.

Function
REQ-014 Address map SHALL be: addr 0 = CTRL/STATUS (bit0 START, bit1 DONE); addr 1..NUM_PARAMS-1 = payload (1 = max_x lo, 2 = max_x hi, 3 = max_y lo, 4 = max_y hi, 5 = kernel_size, 6 = sigma, 7 = reserved).
REQ-015 FSM states SHALL be IDLE, LOAD, ARM, POLL_WAIT, POLL_RD, POLL_CHK, CLEAR.
REQ-016 IDLE with start=1 SHALL go to LOAD with idx=1; start outside IDLE SHALL be ignored.
REQ-017 In LOAD, s_ready SHALL be 1; each s_valid&&s_ready beat SHALL drive wen_params=1, addr_write_params=idx, wdat_params=s_data in the same cycle, then idx++.
REQ-018 A LOAD beat with idx==NUM_PARAMS-1 SHALL move the FSM to ARM; no beats SHALL be accepted outside LOAD.
REQ-019 ARM SHALL write addr 0 = 0x01 for one cycle, clear the poll and timeout counters, and go to POLL_WAIT.
REQ-020 POLL_WAIT SHALL count POLL_INTERVAL cycles, then go to POLL_RD.
REQ-021 POLL_RD SHALL drive ren_params=1 and addr_params=0 for one cycle, then go to POLL_CHK.
REQ-022 POLL_CHK SHALL sample rdat_params: bit1=1 goes to CLEAR with done cause; otherwise it goes to POLL_WAIT.
REQ-023 The timeout counter SHALL increment every cycle in POLL_WAIT, POLL_RD and POLL_CHK, saturating at TIMEOUT_CYCLES; reaching it SHALL go to CLEAR with timeout cause.
REQ-024 If DONE is seen in the same cycle the timeout is reached, done SHALL win.
REQ-025 CLEAR SHALL write addr 0 = 0x00, pulse done or timeout (never both) in that cycle, and go to IDLE.
REQ-026 wen_params and ren_params SHALL never be asserted in the same cycle; at most one SRAM access SHALL occur per cycle.
REQ-027 Outputs SHALL be 0 whenever no access or pulse is specified.

Reset
REQ-028 rst=1 SHALL force IDLE, idx=1, all counters 0, and s_ready, wen_params, ren_params, busy, done and timeout all 0; addr and wdat outputs SHALL be 0.
REQ-029 rst mid-LOAD or mid-POLL SHALL abort with no further SRAM write; the SRAM contents SHALL be left as-is.

Structure
REQ-030 Package param_pkg SHALL hold the address constants (ADDR_CTRL, ADDR_MAXX_LO..ADDR_SIGMA), the CTRL bit indices (START_BIT, DONE_BIT) and the state enum.
REQ-031 Sub-module poll_timer (load/enable, terminal-count output) SHALL be used twice: once for POLL_INTERVAL and once for TIMEOUT_CYCLES.

Verification
REQ-032 Load: start, then 7 beats 0x90,0x01,0x90,0x01,0x07,0x02,0x00 with continuous s_valid -> SRAM[1..7] hold those bytes, SRAM[0]=0x01 one cycle after the last beat.
REQ-033 Backpressure gaps: s_valid toggled 1/0 -> same SRAM image; no writes in gap cycles.
REQ-034 Completion: after ARM, the bench writes SRAM[0]=0x03 -> done pulses exactly once within POLL_INTERVAL+3 cycles; SRAM[0]=0x00; busy=0.
REQ-035 Timeout: TIMEOUT_CYCLES=100 and DONE never set -> timeout pulses at ARM+100 cycles (±1 for the check cycle); done stays 0; SRAM[0]=0x00.
REQ-036 Reset at 3rd LOAD beat -> all outputs 0 next cycle; SRAM[3..7] untouched; a fresh start reloads correctly.
REQ-037 Start pulsed while in POLL_WAIT -> ignored; no extra writes; exactly one done pulse.
